// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit
// ----------------------------------------------------------------------------
// Fetch stage that sits directly in front of the instruction memory.
// It drives the memory address (program counter) and program select, latches
// each returned instruction into an instruction register (IR), and presents
// the decoded fields to the execute stage over a valid/ready handshake.
// The HALT opcode is consumed here: it is never issued, and fetching stops
// until the next start pulse.
//
// Sequence per instruction:
//   FETCH : memory read is combinational; load IR (or stop on HALT)
//   ISSUE : present IR fields with instrValid, wait for instrReady
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   reset            synchronous, active-high reset
//   start            one-cycle pulse, begins a program at address 0
//   programSelectIn  program choice, captured only on an accepted start
//   programSelect    latched program select, drives instruction memory
//   address          program counter, drives instruction memory
//   instruction      combinational read data from instruction memory
//   instrValid       decoded instruction presented to execute
//   instrReady       execute accepts the presented instruction
//   opcode           IR[15:12]
//   fieldA           IR[11:8]  destination register
//   fieldB           IR[7:4]   source 1 register
//   fieldC           IR[3:0]   source 2 register
//   imm              IR[7:0]   immediate for Set to Constant
//   busy             high while fetching or issuing
//   halted           high after a HALT has been fetched
//   instrCount       instructions issued since the last start, saturates at 255
// ============================================================================
module instruction_fetch_unit #(
    parameter int         ADDR_WIDTH  = 8,
    parameter int         INSTR_WIDTH = 16,
    parameter logic [3:0] HALT_OPCODE = 4'b1110
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             programSelectIn,
    output logic [1:0]             programSelect,
    output logic [ADDR_WIDTH-1:0]  address,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [3:0]             opcode,
    output logic [3:0]             fieldA,
    output logic [3:0]             fieldB,
    output logic [3:0]             fieldC,
    output logic [7:0]             imm,
    output logic                   busy,
    output logic                   halted,
    output logic [7:0]             instrCount
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic [1:0]             r_prog_sel;
    logic [1:0]             w_prog_sel_next;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [INSTR_WIDTH-1:0] w_ir_next;
    logic [7:0]             r_count;
    logic [7:0]             w_count_next;

    // Decoded status, produced alongside the next-state logic
    logic                   w_instr_valid;
    logic                   w_busy;
    logic                   w_halted;

    // The opcode field of the word currently on the memory read port
    logic                   w_is_halt;

    assign w_is_halt = (instruction[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the IR is reset along with the control state so that the
            // field outputs read as zero straight out of reset.
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_prog_sel <= '0;
            r_ir       <= '0;
            r_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values computed from the previous cycle's state.
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_prog_sel <= w_prog_sel_next;
            r_ir       <= w_ir_next;
            r_count    <= w_count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in this block gets a default first, so
        // no branch can leave one unassigned and infer a latch.
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_prog_sel_next = r_prog_sel;
        w_ir_next       = r_ir;
        w_count_next    = r_count;
        w_instr_valid   = 1'b0;
        w_busy          = 1'b0;
        w_halted        = 1'b0;

        unique case (r_state)
            S_IDLE, S_HALTED: begin
                w_halted = (r_state == S_HALTED);
                // programSelect is only ever updated here, which keeps it
                // frozen for the whole time the unit is busy.
                if (start) begin
                    w_state_next    = S_FETCH;
                    w_pc_next       = '0;
                    w_prog_sel_next = programSelectIn;
                    w_count_next    = '0;
                end
            end

            S_FETCH: begin
                w_busy = 1'b1;
                // A HALT word is dropped without touching the IR or PC, so
                // address keeps pointing at the HALT location.
                if (w_is_halt) begin
                    w_state_next = S_HALTED;
                end else begin
                    w_ir_next    = instruction;
                    w_state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_busy        = 1'b1;
                w_instr_valid = 1'b1;
                if (instrReady) begin
                    // PC wraps naturally at 2^ADDR_WIDTH; no flag is raised.
                    w_pc_next    = r_pc + ADDR_WIDTH'(1);
                    w_count_next = (r_count == COUNT_MAX) ? r_count
                                                          : r_count + 8'd1;
                    w_state_next = S_FETCH;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign programSelect = r_prog_sel;
    assign address       = r_pc;
    assign instrValid    = w_instr_valid;
    assign busy          = w_busy;
    assign halted        = w_halted;
    assign instrCount    = r_count;

    // Fields come straight from the IR, so they stay stable while an issue
    // is stalled and keep the last value between issues.
    assign opcode = r_ir[15:12];
    assign fieldA = r_ir[11:8];
    assign fieldB = r_ir[7:4];
    assign fieldC = r_ir[3:0];
    assign imm    = r_ir[7:0];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory and drives its `address` and `programSelect` inputs. It latches each returned 16-bit instruction into an instruction register and splits it into opcode and operand fields. It then presents the decoded instruction to the execute stage over a valid/ready handshake. HALT (opcode 1110) is consumed locally and stops fetching until the next `start`.

Parameters:
- ADDR_WIDTH, 8, program counter and `address` width
- INSTR_WIDTH, 16, instruction width; fields below are fixed for 16
- HALT_OPCODE, 4'b1110, opcode that terminates the program

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a program from address 0
- programSelectIn  input  2  program choice, sampled only on an accepted `start`
- programSelect  output  2  latched program select, drives instruction memory
- address  output  ADDR_WIDTH  program counter, drives instruction memory
- instruction  input  INSTR_WIDTH  combinational read data from instruction memory
- instrValid  output  1  decoded instruction is presented to execute
- instrReady  input  1  execute accepts the instruction
- opcode  output  4  IR[15:12]
- fieldA  output  4  IR[11:8]: destination register
- fieldB  output  4  IR[7:4]: source 1 register
- fieldC  output  4  IR[3:0]: source 2 register
- imm  output  8  IR[7:0]: immediate for Set to Constant
- busy  output  1  high in FETCH or ISSUE
- halted  output  1  high in HALTED
- instrCount  output  8  instructions issued since last `start`; saturates at 255

Behaviour:
- Reset: all outputs are 0; the instruction register is 0; state is IDLE. Reset overrides all other inputs in any state, including mid-handshake.
- FSM states: IDLE, FETCH, ISSUE, HALTED.
- IDLE or HALTED, with `start`=1:
  - PC <= 0, `programSelect` <= `programSelectIn`, `instrCount` <= 0, `halted` <= 0.
  - Next state is FETCH.
  - With `start`=0, the block stays in its current state.
- `start` in FETCH or ISSUE is ignored; `programSelect` does not change while `busy`.
- FETCH, single cycle; memory read is combinational:
  - If `instruction`[15:12] == HALT_OPCODE: go to HALTED. Nothing is issued, PC is not incremented, and `address` holds the HALT location.
  - Otherwise: IR <= `instruction`, next state is ISSUE.
- ISSUE:
  - `instrValid`=1; `opcode`, `fieldA`, `fieldB`, `fieldC` and `imm` are driven from IR and stay stable while `instrValid` is high.
  - On `instrValid && instrReady`: PC <= PC+1, `instrCount` <= min(`instrCount`+1, 255), next state is FETCH.
  - Without `instrReady`: hold state, PC and all outputs.
- `instrValid` is 0 in every state except ISSUE.
- Field outputs are valid only when `instrValid`=1; between issues they hold the last IR value.
- Latency:
  - First `instrValid` occurs 2 cycles after `start` is sampled.
  - Peak throughput is one instruction per 2 cycles (FETCH plus ISSUE with `instrReady` high).
- PC wrap: PC at 2^ADDR_WIDTH-1 increments to 0. No flag is raised and fetching continues.
- `busy` = (state==FETCH || state==ISSUE). `halted` = (state==HALTED).

Test Plan:
1. `programSelectIn`=2'b10, `start` pulse, `instrReady`=1 constantly:
   - First issue at start+2 with `opcode`=0000, `fieldA`=1, `imm`=0x02.
   - Five issues total; the fourth has `opcode`=0100, `fieldA`=15, `fieldB`=2, `fieldC`=1.
   - `halted`=1 with `address`=5; `instrCount`=5.
2. Backpressure: hold `instrReady`=0 for 3 cycles during the first issue:
   - `instrValid` stays 1; `opcode`, `fieldA`, `imm` and `address`=0 are stable.
   - Release: `address` becomes 1 the next cycle, and there are no duplicate or lost issues.
3. After test 1 halts, `start` with `programSelectIn`=2'b11:
   - 17 issues; the 15th has `opcode`=0101, `fieldA`=8, `fieldB`=2.
   - Halts at `address`=17; `instrCount`=17; `programSelect`=2'b11.
4. Pulse `start` with `programSelectIn`=2'b00 while `busy`:
   - No effect: `programSelect` is unchanged, and PC and `instrCount` continue.
5. Assert `reset` for 1 cycle during ISSUE of the 3rd instruction:
   - Next cycle all outputs are 0 and state is IDLE.
   - A following `start` restarts at `address`=0.
6. Memory model returning copy instructions (no HALT) with `instrReady`=1:
   - After 256 issues `address` wraps to 0.
   - `instrCount` saturates at 255, `busy` stays 1, and `halted` stays 0.
